// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and execute-stage load/store.
// One access in flight at a time; data has priority over fetch, but after
// STARVE_LIMIT consecutive data grants with fetch waiting, fetch is forced.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} arbStateT;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } memReqT;

  arbStateT   state, stateNext;
  logic [3:0] latCnt;
  logic [3:0] starve, starveNext;
  logic       ownerData;   // 1: data side owns the in-flight access
  logic       ownerWe;     // in-flight data access is a store
  logic       pickFetch, pickData, arbitrate, captureNow;
  memReqT     winReq;

  // Next-state and arbitration; RESP arbitrates too so a waiting request
  // issues right after the response cycle.
  always_comb begin
    stateNext  = state;
    arbitrate  = 1'b0;
    pickFetch  = 1'b0;
    pickData   = 1'b0;
    captureNow = 1'b0;
    case (state)
      IDLE, RESP: begin
        arbitrate = 1'b1;
        if (if_req && (!d_req || starve == STARVE_MAX)) pickFetch = 1'b1;
        else if (d_req)                                  pickData  = 1'b1;
        stateNext = (pickFetch || pickData) ? WAIT : IDLE;
      end
      WAIT: begin
        if (latCnt == 4'd0) begin
          captureNow = 1'b1;
          stateNext  = RESP;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Winner's request; fetch carries no write data.
  always_comb begin
    winReq = '{we: 1'b0, addr: if_addr, wdata: '0};
    if (pickData) winReq = '{we: d_we, addr: d_addr, wdata: d_wdata};
  end

  // Starvation count: consecutive data grants made while fetch was waiting.
  always_comb begin
    starveNext = starve;
    if (arbitrate) begin
      if (pickFetch || !if_req)                 starveNext = 4'd0;
      else if (pickData && starve != STARVE_MAX) starveNext = starve + 4'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Latency countdown: loaded at issue, reaches zero in the data-valid cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  latCnt <= 4'd0;
    else if (pickFetch || pickData)            latCnt <= LAT_LOAD;
    else if (state == WAIT && latCnt != 4'd0)  latCnt <= latCnt - 4'd1;
  end

  // Starve counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve <= 4'd0;
    else      starve <= starveNext;
  end

  // Issue: one-cycle strobes; address/wdata hold until the next issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ownerData <= 1'b0;
      ownerWe   <= 1'b0;
    end else begin
      mem_en <= pickFetch || pickData;
      mem_we <= pickData && winReq.we;
      if_gnt <= pickFetch;
      d_gnt  <= pickData;
      if (pickFetch || pickData) begin
        mem_addr  <= winReq.addr;
        mem_wdata <= winReq.wdata;
        ownerData <= pickData;
        ownerWe   <= pickData && winReq.we;
      end
    end
  end

  // Response: capture read data for the owner only, pulse its rvalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= captureNow && !ownerData;
      d_rvalid  <= captureNow && ownerData;
      if (captureNow && !ownerData)            if_rdata <= mem_rdata;
      if (captureNow && ownerData && !ownerWe) d_rdata  <= mem_rdata;
    end
  end

  assign busy = (state != IDLE);

endmodule
